// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared IEEE-754 single-precision constants, state encoding and classifiers
package fp_pkg;

  localparam int N_W    = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS   = (1 << (EXP_W - 1)) - 1;

  localparam logic [N_W-1:0]   CANON_NAN = 32'hFFC00000;
  localparam logic [EXP_W-1:0] EXP_ONES  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_SPECIAL, S_NORM_IN, S_MULTIPLY, S_NORM_OUT, S_ROUND, S_PACK, S_OUT
  } state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_t;

  function automatic fp_t unpack(input logic [N_W-1:0] x);
    return fp_t'(x);
  endfunction

  function automatic logic is_nan(input fp_t x);
    return (x.exp == EXP_ONES) && (x.frac != '0);
  endfunction

  function automatic logic is_inf(input fp_t x);
    return (x.exp == EXP_ONES) && (x.frac == '0);
  endfunction

  function automatic logic is_zero(input fp_t x);
    return (x.exp == '0) && (x.frac == '0);
  endfunction

  function automatic logic is_denorm(input fp_t x);
    return (x.exp == '0) && (x.frac != '0);
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// rtl/fp_round_pack.sv - round-to-nearest-even then pack with overflow to Inf and underflow flush
module fp_round_pack #(
  parameter int exponent = 8,
  parameter int fraction = 23
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          round_en,
  input  logic                          pack_en,
  input  logic [fraction:0]             mant,
  input  logic                          guard,
  input  logic                          rnd,
  input  logic                          sticky,
  input  logic signed [exponent+1:0]    ze,
  input  logic                          zs,
  output logic [exponent+fraction:0]    z
);
  localparam int EW   = exponent + 2;
  localparam int bias = (1 << (exponent - 1)) - 1;
  localparam logic signed [EW-1:0] BIAS_S = EW'(bias);
  localparam logic signed [EW-1:0] MIN_E  = EW'(1 - bias);
  localparam logic signed [EW-1:0] ONE_S  = 1;

  logic [fraction+1:0]  sum;
  logic                 inc;
  logic [fraction:0]    rm;
  logic signed [EW-1:0] rze, biased;
  logic                 rzs;

  assign inc    = guard & (rnd | sticky | mant[0]);
  assign sum    = {1'b0, mant} + {{(fraction+1){1'b0}}, inc};
  assign biased = rze + BIAS_S;

  always_ff @(posedge clk) begin
    if (rst) begin
      z <= '0;
    end else begin
      if (round_en) begin
        rzs <= zs;
        // Carry-out means the mantissa rounded up to exactly 2.0
        if (sum[fraction+1]) begin
          rm  <= {1'b1, {fraction{1'b0}}};
          rze <= ze + ONE_S;
        end else begin
          rm  <= sum[fraction:0];
          rze <= ze;
        end
      end
      if (pack_en) begin
        if (rze > BIAS_S)
          z <= {rzs, {exponent{1'b1}}, {fraction{1'b0}}};
        else if (rze < MIN_E)
          z <= {rzs, {(exponent+fraction){1'b0}}};
        else
          z <= {rzs, biased[exponent-1:0], rm[fraction-1:0]};
      end
    end
  end

endmodule

// File: rtl/fp_multiplier.sv
// rtl/fp_multiplier.sv - multi-cycle IEEE-754 multiplier feeding the neuron FP adder
module fp_multiplier
  import fp_pkg::*;
#(
  parameter int n        = N_W,
  parameter int exponent = EXP_W,
  parameter int fraction = FRAC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] input_a,
  input  logic [n-1:0] input_b,
  input  logic         input_valid,
  output logic         input_ready,
  output logic [n-1:0] output_z,
  output logic         output_valid,
  input  logic         output_ready
);
  localparam int EW   = exponent + 2;
  localparam int MW   = fraction + 1;
  localparam int PW   = 2 * MW;
  localparam int bias = (1 << (exponent - 1)) - 1;
  localparam logic signed [EW-1:0] BIAS_S     = EW'(bias);
  localparam logic signed [EW-1:0] EXP_DENORM = EW'(1 - bias);
  localparam logic signed [EW-1:0] ONE_S      = 1;

  state_t               state, state_n;
  fp_t                  ua, ub, a_q, b_q;
  logic signed [EW-1:0] ea, eb, ze;
  logic [MW-1:0]        ma, mb, mant;
  logic [PW-1:0]        prod;
  logic                 zs, guard, rnd, sticky, special;
  logic [n-1:0]         z_spec, z_spec_n, rp_z;
  logic                 spec_hit;

  assign ua          = unpack(input_a);
  assign ub          = unpack(input_b);
  assign input_ready = (state == S_IDLE);

  always_comb begin
    spec_hit = 1'b1;
    z_spec_n = CANON_NAN;
    if (is_nan(a_q) || is_nan(b_q) || (is_inf(a_q) && is_zero(b_q)) ||
        (is_zero(a_q) && is_inf(b_q)))
      z_spec_n = CANON_NAN;
    else if (is_inf(a_q) || is_inf(b_q))
      z_spec_n = {a_q.sign ^ b_q.sign, {exponent{1'b1}}, {fraction{1'b0}}};
    else if (is_zero(a_q) || is_zero(b_q))
      z_spec_n = {a_q.sign ^ b_q.sign, {(n-1){1'b0}}};
    else
      spec_hit = 1'b0;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (input_valid) state_n = S_SPECIAL;
      S_SPECIAL:  state_n = spec_hit ? S_OUT : S_NORM_IN;
      S_NORM_IN:  if (ma[MW-1] && mb[MW-1]) state_n = S_MULTIPLY;
      S_MULTIPLY: state_n = S_NORM_OUT;
      S_NORM_OUT: state_n = S_ROUND;
      S_ROUND:    state_n = S_PACK;
      S_PACK:     state_n = S_OUT;
      S_OUT:      if (output_valid && output_ready) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      output_valid <= 1'b0;
      output_z     <= '0;
      special      <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: if (input_valid) begin
          a_q <= ua;
          b_q <= ub;
          ea  <= (ua.exp == '0) ? EXP_DENORM : $signed({2'b00, ua.exp}) - BIAS_S;
          eb  <= (ub.exp == '0) ? EXP_DENORM : $signed({2'b00, ub.exp}) - BIAS_S;
          ma  <= {ua.exp != '0, ua.frac};
          mb  <= {ub.exp != '0, ub.frac};
        end
        S_SPECIAL: begin
          special <= spec_hit;
          z_spec  <= z_spec_n;
        end
        // Denormals walk up one bit per clock, A before B
        S_NORM_IN:
          if (!ma[MW-1]) begin
            ma <= ma << 1;
            ea <= ea - ONE_S;
          end else if (!mb[MW-1]) begin
            mb <= mb << 1;
            eb <= eb - ONE_S;
          end
        S_MULTIPLY: begin
          prod <= PW'(ma) * PW'(mb);
          ze   <= ea + eb;
          zs   <= a_q.sign ^ b_q.sign;
        end
        S_NORM_OUT:
          if (prod[PW-1]) begin
            mant   <= prod[PW-1:MW];
            guard  <= prod[MW-1];
            rnd    <= prod[MW-2];
            sticky <= |prod[MW-3:0];
            ze     <= ze + ONE_S;
          end else begin
            mant   <= prod[PW-2:MW-1];
            guard  <= prod[MW-2];
            rnd    <= prod[MW-3];
            sticky <= |prod[MW-4:0];
          end
        S_OUT:
          if (!output_valid) begin
            output_valid <= 1'b1;
            output_z     <= special ? z_spec : rp_z;
          end else if (output_ready) begin
            output_valid <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  fp_round_pack #(.exponent(exponent), .fraction(fraction)) u_round_pack (
    .clk      (clk),
    .rst      (rst),
    .round_en (state == S_ROUND),
    .pack_en  (state == S_PACK),
    .mant     (mant),
    .guard    (guard),
    .rnd      (rnd),
    .sticky   (sticky),
    .ze       (ze),
    .zs       (zs),
    .z        (rp_z)
  );

endmodule

// File: tb/tb_fp_multiplier.sv
// tb/tb_fp_multiplier.sv - vector table, corner sequences and random ops against a value-level model
module tb_fp_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a, input_b, output_z;
  logic        input_valid, input_ready, output_valid, output_ready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_multiplier dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_b      (input_b),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .output_z     (output_z),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int msb64(input longint unsigned x);
    for (int i = 63; i >= 0; i--)
      if (x[i]) return i;
    return -1;
  endfunction

  // Value-level reference: operand = sig * 2^e, exact integer product, then RNE to 24 bits
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b, output int lat);
    logic [7:0] xa, xb;
    logic s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    longint unsigned siga, sigb, p, q, rem, half;
    int ea, eb, k, sh, ue;
    xa = a[30:23];
    xb = b[30:23];
    s = a[31] ^ b[31];
    nan_a  = (xa == 8'hFF) && (a[22:0] != 0);
    nan_b  = (xb == 8'hFF) && (b[22:0] != 0);
    inf_a  = (xa == 8'hFF) && (a[22:0] == 0);
    inf_b  = (xb == 8'hFF) && (b[22:0] == 0);
    zero_a = (a[30:0] == 0);
    zero_b = (b[30:0] == 0);
    lat = 2;
    if (nan_a || nan_b || (inf_a && zero_b) || (zero_a && inf_b)) return 32'hFFC00000;
    if (inf_a || inf_b) return {s, 8'hFF, 23'd0};
    if (zero_a || zero_b) return {s, 31'd0};
    siga = {40'd0, xa != 0, a[22:0]};
    sigb = {40'd0, xb != 0, b[22:0]};
    ea = (xa == 0) ? -149 : int'(xa) - 150;
    eb = (xb == 0) ? -149 : int'(xb) - 150;
    lat = 7 + (23 - msb64(siga)) + (23 - msb64(sigb));
    p  = siga * sigb;
    k  = msb64(p);
    sh = k - 23;
    if (sh > 0) begin
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
        q  = q >> 1;
        sh = sh + 1;
      end
    end else begin
      q = p << (-sh);
    end
    ue = ea + eb + sh + 23;
    if (ue > 127) return {s, 8'hFF, 23'd0};
    if (ue < -126) return {s, 31'd0};
    return {s, 8'(ue + 127), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[30:23] = 8'h00;
      1: r[30:23] = 8'hFF;
      2: r[22:0]  = 23'd0;
      3: begin r[30:23] = 8'h00; r[22:0] = 23'd1 << $urandom_range(0, 22); end
      4: r[30:0]  = 31'd0;
      default: r[30:23] = 8'($urandom_range(70, 184));
    endcase
    return r;
  endfunction

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] z, output int lat);
    @(negedge clk);
    input_a     = a;
    input_b     = b;
    input_valid = 1'b1;
    @(posedge clk);
    #1 input_valid = 1'b0;
    lat = 0;
    while (!output_valid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    z = output_z;
    output_ready = 1'b1;
    @(posedge clk);
    #1 output_ready = 1'b0;
  endtask

  initial begin
    vec_t        vecs[7];
    logic [31:0] z, ez, z0;
    int          lat, elat, waited;

    vecs[0] = '{32'h40000000, 32'h40400000, 32'h40C00000, 7};
    vecs[1] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 7};
    vecs[2] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, 7};
    vecs[3] = '{32'h7F800000, 32'h00000000, 32'hFFC00000, 2};
    vecs[4] = '{32'h7F000000, 32'h40000000, 32'h7F800000, 7};
    vecs[5] = '{32'h80800000, 32'h3F000000, 32'h80000000, 7};
    vecs[6] = '{32'h00000001, 32'h4B000000, 32'h00800000, 30};

    rst = 1'b1;
    input_valid  = 1'b0;
    output_ready = 1'b0;
    input_a = '0;
    input_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(output_valid), 32'd0);
    check("reset_z", output_z, 32'd0);
    check("reset_ready", 32'(input_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, z, lat);
      check($sformatf("vec%0d_z", i), z, vecs[i].z);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_idle", i), {30'd0, input_ready, output_valid}, 32'd2);
    end

    // Back-pressure with a competing input held valid throughout
    @(negedge clk);
    input_a = 32'h40000000;
    input_b = 32'h40400000;
    input_valid = 1'b1;
    @(posedge clk);
    #1 input_a = 32'h3F800000;
    input_b = 32'h3F800000;
    waited = 0;
    while (!output_valid && waited < 200) begin
      @(posedge clk);
      #1 waited++;
    end
    check("bp_lat", 32'(waited), 32'd7);
    z0 = output_z;
    check("bp_z", z0, 32'h40C00000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold_valid%0d", i), 32'(output_valid), 32'd1);
      check($sformatf("bp_hold_z%0d", i), output_z, z0);
      check($sformatf("bp_hold_ready%0d", i), 32'(input_ready), 32'd0);
    end
    output_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_xfer_valid", 32'(output_valid), 32'd0);
    check("bp_xfer_ready", 32'(input_ready), 32'd1);
    input_valid  = 1'b0;
    output_ready = 1'b0;

    // Reset while the denormal operand is still being normalised
    @(negedge clk);
    input_a = 32'h00000001;
    input_b = 32'h4B000000;
    input_valid = 1'b1;
    @(posedge clk);
    #1 input_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", 32'(output_valid), 32'd0);
    check("rst_mid_ready", 32'(input_ready), 32'd1);
    check("rst_mid_z", output_z, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(32'h40000000, 32'h40400000, z, lat);
    check("post_rst_z", z, 32'h40C00000);
    check("post_rst_lat", 32'(lat), 32'd7);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra, rb;
      ra = rand_op();
      rb = rand_op();
      ez = ref_mul(ra, rb, elat);
      do_op(ra, rb, z, lat);
      check($sformatf("rand%0d_z_%08h_%08h", i, ra, rb), z, ez);
      check($sformatf("rand%0d_lat", i), 32'(lat), 32'(elat));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
